seq_datapath: RTL and testbench

Parametrised, self-sequencing register-file datapath: NREGS registers of WIDTH bits, an operand latch, an ALU, and a small controller that runs one instruction per start/done handshake. It includes a multi-cycle shift-add multiply. It sits between the lab-level instruction sequencer and the display/output logic, and replaces the fixed 4×8-bit, externally-steered datapath. Register 0 is mirrored to `out` as before.

---
 rtl/dp_pkg.sv | 29 ++
 rtl/dp_alu.sv | 35 +++
 rtl/seq_datapath.sv | 156 +++++++++++++++
 tb/tb_seq_datapath.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_pkg
// Brief    : Shared types for seq_datapath: op-code and controller state enums.
// Revision : 1.0 - initial release
// ============================================================================
package dp_pkg;

  // Instruction op-codes as presented on the 3-bit op port.
  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_MOV  = 3'b001,
    OP_XOR  = 3'b010,
    OP_AND  = 3'b011,
    OP_SHL  = 3'b100,
    OP_ADD  = 3'b101,
    OP_MUL  = 3'b110,
    OP_NOP  = 3'b111
  } op_e;

  // Controller states; S_MUL is only reachable when the multiplier is built.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_e;

endpackage : dp_pkg
`default_nettype wire

// File: rtl/dp_alu.sv
`default_nettype none
// ============================================================================
// Module   : dp_alu
// Brief    : Combinational ALU for the single-cycle ops (LOAD..ADD).
//            MUL and NOP produce zero; the controller never writes them here.
// Revision : 1.0 - initial release
// ============================================================================
module dp_alu
  import dp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result
);

  // Select the result for the latched op; carry and shifted-out MSB are dropped.
  always_comb begin
    result = '0;
    case (op)
      OP_LOAD: result = imm;
      OP_MOV:  result = b;
      OP_XOR:  result = a ^ b;
      OP_AND:  result = a & b;
      OP_SHL:  result = a << 1;
      OP_ADD:  result = a + b;
      default: result = '0;
    endcase
  end

endmodule : dp_alu
`default_nettype wire

// File: rtl/seq_datapath.sv
`default_nettype none
// ============================================================================
// Module   : seq_datapath
// Brief    : Self-sequencing register-file datapath. One instruction per
//            start/done handshake; R[0] is mirrored to out.
//            Optional feature macro: DP_MUL_EN (builds the shift-add
//            multiplier; otherwise op 110 completes as a NOP).
// Revision : 1.0 - initial release
// ============================================================================
module seq_datapath
  import dp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    ra,
  input  logic [RW-1:0]    rb,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic             z,
  output logic [WIDTH-1:0] out
);

  state_e           r_state, w_next_state;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_a, r_b, r_imm;
  op_e              r_op;
  logic [RW-1:0]    r_rd;
  logic             r_done, r_z;
  logic [WIDTH-1:0] r_out;

  logic             w_accept, w_wr_en, w_done;
  logic [WIDTH-1:0] w_wr_data, w_alu;

`ifdef DP_MUL_EN
  localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] r_acc;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] w_mul_sum;
  logic             w_mul_last;

  // One shift-add step: add A into the accumulator when B's LSB is set.
  assign w_mul_sum  = r_acc + (r_b[0] ? r_a : '0);
  assign w_mul_last = (r_cnt == c_CW'(WIDTH - 1));
`endif

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .imm    (r_imm),
    .result (w_alu)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state, issue and writeback decisions.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_wr_en      = 1'b0;
    w_done       = 1'b0;
    w_wr_data    = w_alu;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_EXEC;
`ifdef DP_MUL_EN
          if (op_e'(op) == OP_MUL) w_next_state = S_MUL;
`endif
        end
      end
      S_EXEC: begin
        // MUL only lands here when the multiplier is not built: treat as NOP.
        w_wr_en      = (r_op != OP_NOP) && (r_op != OP_MUL);
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
`ifdef DP_MUL_EN
      S_MUL: begin
        if (w_mul_last) begin
          w_wr_en      = 1'b1;
          w_wr_data    = w_mul_sum;
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand latches, register file, flags and the R[0] mirror.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_imm  <= '0;
      r_op   <= OP_LOAD;
      r_rd   <= '0;
      r_done <= 1'b0;
      r_z    <= 1'b0;
      r_out  <= '0;
`ifdef DP_MUL_EN
      r_acc  <= '0;
      r_cnt  <= '0;
`endif
    end else begin
      r_done <= w_done;
      r_out  <= r_regs[0];
      if (w_accept) begin
        r_op  <= op_e'(op);
        r_rd  <= rd;
        r_imm <= in;
        r_a   <= r_regs[ra];
        r_b   <= r_regs[rb];
`ifdef DP_MUL_EN
        r_acc <= '0;
        r_cnt <= '0;
`endif
      end
`ifdef DP_MUL_EN
      if (r_state == S_MUL) begin
        r_acc <= w_mul_sum;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + c_CW'(1);
      end
`endif
      if (w_wr_en) begin
        r_regs[r_rd] <= w_wr_data;
        r_z          <= (w_wr_data == '0);
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign z    = r_z;
  assign out  = r_out;

endmodule : seq_datapath
`default_nettype wire

// File: tb/tb_seq_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_datapath
// Brief    : Self-checking bench for seq_datapath: directed test-plan steps
//            followed by random instructions against a behavioural model.
//            Honors DP_MUL_EN to pick the expected op-110 behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_datapath;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int RW    = 2;
  localparam int MOD   = 1 << WIDTH;
`ifdef DP_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = '0;
  logic [RW-1:0]    rd = '0, ra = '0, rb = '0;
  logic [WIDTH-1:0] in = '0;
  wire              busy, done, z;
  wire  [WIDTH-1:0] out;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: register contents and zero flag.
  int m_reg [NREGS];
  bit m_z;

  seq_datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .rd    (rd),
    .ra    (ra),
    .rb    (rb),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .out   (out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_reg[i] = 0;
    m_z = 1'b0;
  endtask

  // Architectural effect of one instruction from the op-code table.
  task automatic model_exec(input int o, input int d, input int s1, input int s2, input int imm);
    int a, b, res;
    bit wr;
    a = m_reg[s1];
    b = m_reg[s2];
    wr = 1'b1;
    res = 0;
    case (o)
      0: res = imm;
      1: res = b;
      2: res = a ^ b;
      3: res = a & b;
      4: res = (a * 2) % MOD;
      5: res = (a + b) % MOD;
      6: begin res = (a * b) % MOD; wr = MUL_EN; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_reg[d] = res;
      m_z = (res == 0);
    end
  endtask

  // Issue one instruction with a one-cycle start pulse and check the handshake.
  task automatic run_instr(input int o, input int d, input int s1, input int s2,
                           input int imm, input bit poke);
    int lat;
    int old_r0;
    lat = (o == 6 && MUL_EN) ? WIDTH : 1;
    old_r0 = m_reg[0];
    @(negedge clk);
    start = 1'b1; op = 3'(o); rd = RW'(d); ra = RW'(s1); rb = RW'(s2); in = WIDTH'(imm);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    for (int k = 1; k <= lat; k++) begin
      if (poke && k == 3 && lat > 3) begin
        start = 1'b1; op = 3'd0; rd = RW'(d); in = ~WIDTH'(imm);
      end
      @(negedge clk);
      start = 1'b0;
      if (k < lat) begin
        chk("busy_mid", busy, 1);
        chk("done_mid", done, 0);
      end else begin
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("out_lag", out, old_r0);
      end
    end
    model_exec(o, d, s1, s2, imm);
    chk("reg_rd", dut.r_regs[d], m_reg[d]);
    chk("z_flag", z, m_z);
    @(negedge clk);
    chk("done_clears", done, 0);
    chk("out_mirror", out, m_reg[0]);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state holds while idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_out", out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_z", z, 0);
    end

    // LOAD/LOAD/XOR into R0.
    run_instr(0, 1, 0, 0, 8'h3C, 1'b0);
    run_instr(0, 2, 0, 0, 8'h0F, 1'b0);
    run_instr(2, 0, 1, 2, 0, 1'b0);
    chk("xor_r0", out, 8'h33);

    // MUL with an ignored start poke at t+3.
    run_instr(6, 3, 1, 2, 8'h11, 1'b1);
    chk("mul_r3", dut.r_regs[3], MUL_EN ? 8'h84 : 8'h00);

    // ADD wraps to zero, SHL drops MSB, NOP holds z.
    run_instr(0, 1, 0, 0, 8'hFF, 1'b0);
    run_instr(0, 3, 0, 0, 8'h01, 1'b0);
    run_instr(5, 1, 1, 3, 0, 1'b0);
    chk("add_wrap", dut.r_regs[1], 0);
    chk("add_z", z, 1);
    run_instr(0, 2, 0, 0, 8'h81, 1'b0);
    run_instr(4, 2, 2, 0, 0, 1'b0);
    chk("shl_val", dut.r_regs[2], 8'h02);
    chk("shl_z", z, 0);
    run_instr(7, 0, 0, 0, 0, 1'b0);
    chk("nop_z", z, 0);

    // Reset in the middle of a MUL aborts everything immediately.
    run_instr(0, 0, 0, 0, 8'h5A, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd6; rd = 2'd3; ra = 2'd1; rb = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", out, 0);
    chk("abort_z", z, 0);
    for (int i = 0; i < NREGS; i++) chk("abort_reg", dut.r_regs[i], 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back issue with start held high: LOAD R0 then MOV R1<-R0.
    @(negedge clk);
    start = 1'b1; op = 3'd0; rd = 2'd0; in = 8'hAA;
    @(negedge clk);
    op = 3'd1; rd = 2'd1; rb = 2'd0; in = 8'h00;
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_busy1", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_gap_done", done, 0);
    chk("b2b_gap_busy", busy, 1);
    @(negedge clk);
    chk("b2b_done2", done, 1);
    model_exec(0, 0, 0, 0, 8'hAA);
    model_exec(1, 1, 0, 0, 0);
    chk("b2b_r1", dut.r_regs[1], m_reg[1]);
    chk("b2b_r0", dut.r_regs[0], m_reg[0]);
    @(negedge clk);
    chk("b2b_out", out, 8'hAA);

    // Random instructions against the model.
    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, NREGS - 1)),
                int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)),
                int'($urandom_range(0, MOD - 1)), bit'($urandom_range(0, 1)));
    end
    for (int i = 0; i < NREGS; i++) chk("final_reg", dut.r_regs[i], m_reg[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_seq_datapath
`default_nettype wire
